pll_reset_sequencer: RTL and testbench

- Supervises the core PLL, which generates the 96 MHz, 96 MHz phase-shifted, 6 MHz and 6 MHz phase-shifted clocks from the 74.25 MHz reference.
- Runs on the 74.25 MHz reference clock. Drives the PLL reset, waits for a stable lock, and then releases an active-low reset to the downstream core logic.
- Retries the PLL after a lock timeout or a lock loss. Latches a fault after too many failed attempts.

---
 rtl/pll_reset_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
//
// Supervises the core PLL, which derives the 96 MHz / 6 MHz clock family from
// the 74.25 MHz reference. The block holds the PLL in reset for a fixed
// number of cycles, waits for the lock flag and requires it to stay high for
// a stable window before releasing the downstream core reset. A missing lock
// is retried a limited number of times before the block parks the PLL in
// reset and flags a fault. A lock loss while running restarts the whole
// sequence with a fresh retry budget.
//
// Ports
//   i_clk_74a        in   74.25 MHz reference clock, sole clock of the block
//   i_reset_n        in   synchronous active-low reset
//   i_pll_locked     in   PLL lock flag, asynchronous to i_clk_74a
//   i_relock_req     in   single-cycle request to restart sequencing
//   o_pll_rst        out  PLL reset, active-high
//   o_sys_reset_n    out  downstream core reset, active-low
//   o_ready          out  high only while running
//   o_fault          out  high only while faulted
//   o_retry_count    out  lock-timeout retries consumed in this sequence
//
// FSM states
//   state        | meaning
//   -------------+----------------------------------------------------------
//   S_RESET_PLL  | PLL held in reset for RESET_CYCLES cycles
//   S_WAIT_LOCK  | PLL released, waiting for synchronized lock (with timeout)
//   S_STABILIZE  | lock seen, must persist LOCK_STABLE_CYCLES cycles
//   S_RUN        | core reset released, watching for lock loss
//   S_FAULT      | retry budget exhausted, PLL parked in reset
// -----------------------------------------------------------------------------
module pll_reset_sequencer #(
  parameter int unsigned RESET_CYCLES        = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 742500,
  parameter int unsigned MAX_RETRIES         = 7
) (
  input  logic       i_clk_74a,
  input  logic       i_reset_n,
  input  logic       i_pll_locked,
  input  logic       i_relock_req,
  output logic       o_pll_rst,
  output logic       o_sys_reset_n,
  output logic       o_ready,
  output logic       o_fault,
  output logic [3:0] o_retry_count
);

  // Terminal counts, pre-computed so the compares are plain equality checks.
  localparam logic [23:0] RST_LAST  = 24'(RESET_CYCLES - 1);
  localparam logic [23:0] STB_LAST  = 24'(LOCK_STABLE_CYCLES - 1);
  localparam logic [23:0] TOUT_LAST = 24'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABILIZE = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [23:0] r_cnt;
  logic [23:0] w_cnt_nxt;
  logic [3:0]  r_retry;
  logic [3:0]  w_retry_nxt;

  logic        r_lock_meta;
  logic        r_lock_s;

  logic        r_pll_rst;
  logic        r_sys_reset_n;
  logic        r_ready;
  logic        r_fault;
  logic        w_pll_rst_nxt;
  logic        w_sys_reset_n_nxt;
  logic        w_ready_nxt;
  logic        w_fault_nxt;

  // Two-flop synchronizer for the asynchronous lock flag. Clearing it on
  // reset guarantees a fresh sequence never sees a stale lock.
  always_ff @(posedge i_clk_74a) begin
    if (!i_reset_n) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= i_pll_locked;
      r_lock_s    <= r_lock_meta;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge i_clk_74a) begin
    if (!i_reset_n) begin
      r_state       <= S_RESET_PLL;
      r_cnt         <= 24'd0;
      r_retry       <= 4'd0;
      r_pll_rst     <= 1'b1;
      r_sys_reset_n <= 1'b0;
      r_ready       <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_retry       <= w_retry_nxt;
      r_pll_rst     <= w_pll_rst_nxt;
      r_sys_reset_n <= w_sys_reset_n_nxt;
      r_ready       <= w_ready_nxt;
      r_fault       <= w_fault_nxt;
    end
  end

  // Next-state logic. A relock request overrides every state condition,
  // including restarting a reset pulse already in progress.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_retry_nxt = r_retry;

    if (i_relock_req) begin
      w_state_nxt = S_RESET_PLL;
      w_cnt_nxt   = 24'd0;
      w_retry_nxt = 4'd0;
    end else begin
      case (r_state)
        S_RESET_PLL: begin
          if (r_cnt == RST_LAST) begin
            w_state_nxt = S_WAIT_LOCK;
            w_cnt_nxt   = 24'd0;
          end else begin
            w_cnt_nxt = r_cnt + 24'd1;
          end
        end

        S_WAIT_LOCK: begin
          // Lock is tested first so a lock arriving on the timeout cycle wins.
          if (r_lock_s) begin
            w_state_nxt = S_STABILIZE;
            w_cnt_nxt   = 24'd0;
          end else if (r_cnt == TOUT_LAST) begin
            w_cnt_nxt = 24'd0;
            if (r_retry == RETRY_MAX) begin
              w_state_nxt = S_FAULT;
            end else begin
              w_state_nxt = S_RESET_PLL;
              w_retry_nxt = r_retry + 4'd1;
            end
          end else begin
            w_cnt_nxt = r_cnt + 24'd1;
          end
        end

        S_STABILIZE: begin
          // A drop on the final count cycle still sends us back to wait;
          // the timeout window restarts but the retry budget is kept.
          if (!r_lock_s) begin
            w_state_nxt = S_WAIT_LOCK;
            w_cnt_nxt   = 24'd0;
          end else if (r_cnt == STB_LAST) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = 24'd0;
          end else begin
            w_cnt_nxt = r_cnt + 24'd1;
          end
        end

        S_RUN: begin
          // Lock loss while running is a new sequence, so the budget resets.
          if (!r_lock_s) begin
            w_state_nxt = S_RESET_PLL;
            w_cnt_nxt   = 24'd0;
            w_retry_nxt = 4'd0;
          end
        end

        S_FAULT: begin
          w_state_nxt = S_FAULT;
        end

        default: begin
          w_state_nxt = S_RESET_PLL;
          w_cnt_nxt   = 24'd0;
          w_retry_nxt = 4'd0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they register on the same
  // edge as the transition.
  always_comb begin
    w_pll_rst_nxt     = 1'b0;
    w_sys_reset_n_nxt = 1'b0;
    w_ready_nxt       = 1'b0;
    w_fault_nxt       = 1'b0;
    case (w_state_nxt)
      S_RESET_PLL: w_pll_rst_nxt = 1'b1;
      S_RUN: begin
        w_sys_reset_n_nxt = 1'b1;
        w_ready_nxt       = 1'b1;
      end
      S_FAULT: begin
        w_pll_rst_nxt = 1'b1;
        w_fault_nxt   = 1'b1;
      end
      default: begin
        w_pll_rst_nxt = 1'b0;
      end
    endcase
  end

  assign o_pll_rst     = r_pll_rst;
  assign o_sys_reset_n = r_sys_reset_n;
  assign o_ready       = r_ready;
  assign o_fault       = r_fault;
  assign o_retry_count = r_retry;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// Table of {inputs, cycles to advance, expected outputs} records applied in
// order, with a hand-written loop for the long FAULT hold and a per-cycle
// invariant monitor. Timing: RESET_CYCLES=4, LOCK_STABLE_CYCLES=8,
// LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
// -----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

  logic       clk;
  logic       reset_n;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       sys_reset_n;
  logic       ready;
  logic       fault;
  logic [3:0] retry_count;

  int checks   = 0;
  int failures = 0;
  bit inv_en   = 1'b0;

  pll_reset_sequencer #(
    .RESET_CYCLES        (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32),
    .MAX_RETRIES         (2)
  ) dut (
    .i_clk_74a     (clk),
    .i_reset_n     (reset_n),
    .i_pll_locked  (pll_locked),
    .i_relock_req  (relock_req),
    .o_pll_rst     (pll_rst),
    .o_sys_reset_n (sys_reset_n),
    .o_ready       (ready),
    .o_fault       (fault),
    .o_retry_count (retry_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       locked;
    logic       relock;
    int         n;
    logic       e_pll_rst;
    logic       e_sysn;
    logic       e_ready;
    logic       e_fault;
    logic [3:0] e_retry;
    string      name;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic rst_n, input logic locked, input logic relock,
                              input int n, input logic e_pr, input logic e_sn,
                              input logic e_rd, input logic e_ft, input logic [3:0] e_rt,
                              input string name);
    vec_t v;
    v.rst_n = rst_n; v.locked = locked; v.relock = relock; v.n = n;
    v.e_pll_rst = e_pr; v.e_sysn = e_sn; v.e_ready = e_rd; v.e_fault = e_ft;
    v.e_retry = e_rt; v.name = name;
    vq.push_back(v);
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_out(input string name, input logic [7:0] exp_v);
    logic [7:0] got;
    got = {pll_rst, sys_reset_n, ready, fault, retry_count};
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL %s: got {pll_rst,sys_reset_n,ready,fault,retry}=%b_%b_%b_%b_%0d expected %b_%b_%b_%b_%0d",
               name, got[7], got[6], got[5], got[4], got[3:0],
               exp_v[7], exp_v[6], exp_v[5], exp_v[4], exp_v[3:0]);
    end
  endtask

  task automatic run_range(input int first, input int last);
    for (int i = first; i < last; i++) begin
      reset_n    = vq[i].rst_n;
      pll_locked = vq[i].locked;
      relock_req = vq[i].relock;
      step(vq[i].n);
      check_out(vq[i].name, {vq[i].e_pll_rst, vq[i].e_sysn, vq[i].e_ready,
                             vq[i].e_fault, vq[i].e_retry});
    end
  endtask

  always @(negedge clk) begin
    if (inv_en) begin
      checks++;
      if ((ready && !sys_reset_n) || (ready && fault) || (pll_rst && sys_reset_n)) begin
        failures++;
        $display("FAIL invariant: pll_rst=%b sys_reset_n=%b ready=%b fault=%b at %0t",
                 pll_rst, sys_reset_n, ready, fault, $time);
      end
    end
  end

  initial begin
    int split;
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    relock_req = 1'b0;

    //   rst lk rl   n   prst sysn rdy flt rty  name
    // Normal start: reset released before edge 0, lock rises at edge 10.
    add(0, 0, 0,  3,  1, 0, 0, 0, 0, "reset_values");
    add(1, 0, 0,  3,  1, 0, 0, 0, 0, "rst_pulse_high");
    add(1, 0, 0,  1,  0, 0, 0, 0, 0, "rst_pulse_end");
    add(1, 0, 0,  6,  0, 0, 0, 0, 0, "wait_no_lock");
    add(1, 1, 0,  2,  0, 0, 0, 0, 0, "lock_sync_latency");
    add(1, 1, 0,  8,  0, 0, 0, 0, 0, "stabilize_not_ready");
    add(1, 1, 0,  1,  0, 1, 1, 0, 0, "run_at_edge20");
    // Lock loss in RUN.
    add(1, 0, 0,  2,  0, 1, 1, 0, 0, "loss_sync_latency");
    add(1, 0, 0,  1,  1, 0, 0, 0, 0, "loss_to_reset");
    add(1, 0, 0,  3,  1, 0, 0, 0, 0, "loss_pulse_high");
    add(1, 0, 0,  1,  0, 0, 0, 0, 0, "loss_pulse_end");
    add(1, 1, 0, 10,  0, 0, 0, 0, 0, "relock_not_ready");
    add(1, 1, 0,  1,  0, 1, 1, 0, 0, "rerun");
    // relock_req from RUN, then one timeout to consume a retry.
    add(1, 0, 1,  1,  1, 0, 0, 0, 0, "relock_from_run");
    add(1, 0, 0,  3,  1, 0, 0, 0, 0, "relock_pulse_high");
    add(1, 0, 0,  1,  0, 0, 0, 0, 0, "relock_pulse_end");
    add(1, 0, 0, 31,  0, 0, 0, 0, 0, "timeout_minus1");
    add(1, 0, 0,  1,  1, 0, 0, 0, 1, "timeout_retry1");
    add(1, 0, 0,  3,  1, 0, 0, 0, 1, "retry_pulse_high");
    add(1, 0, 0,  1,  0, 0, 0, 0, 1, "retry_pulse_end");
    // One-cycle glitch during STABILIZE: ready delayed by a full window.
    add(1, 1, 0,  7,  0, 0, 0, 0, 1, "stabilize_pre_glitch");
    add(1, 0, 0,  1,  0, 0, 0, 0, 1, "glitch_cycle");
    add(1, 1, 0, 10,  0, 0, 0, 0, 1, "glitch_delays_ready");
    add(1, 1, 0,  1,  0, 1, 1, 0, 1, "glitch_run_retry_kept");
    // Lock loss clears retries, then three timeouts end in FAULT.
    add(1, 0, 0,  2,  0, 1, 1, 0, 1, "loss2_latency");
    add(1, 0, 0,  1,  1, 0, 0, 0, 0, "loss_clears_retry");
    add(1, 0, 0,  3,  1, 0, 0, 0, 0, "w1_pulse_high");
    add(1, 0, 0,  1,  0, 0, 0, 0, 0, "w1_start");
    add(1, 0, 0, 31,  0, 0, 0, 0, 0, "w1_minus1");
    add(1, 0, 0,  1,  1, 0, 0, 0, 1, "w1_timeout");
    add(1, 0, 0,  3,  1, 0, 0, 0, 1, "w2_pulse_high");
    add(1, 0, 0,  1,  0, 0, 0, 0, 1, "w2_start");
    add(1, 0, 0, 31,  0, 0, 0, 0, 1, "w2_minus1");
    add(1, 0, 0,  1,  1, 0, 0, 0, 2, "w2_timeout");
    add(1, 0, 0,  3,  1, 0, 0, 0, 2, "w3_pulse_high");
    add(1, 0, 0,  1,  0, 0, 0, 0, 2, "w3_start");
    add(1, 0, 0, 31,  0, 0, 0, 0, 2, "w3_minus1");
    add(1, 0, 0,  1,  1, 0, 0, 1, 2, "fault_entered");
    split = vq.size();
    // relock_req from FAULT, and a second request restarting the pulse.
    add(1, 0, 1,  1,  1, 0, 0, 0, 0, "relock_from_fault");
    add(1, 0, 0,  2,  1, 0, 0, 0, 0, "pulse_partial");
    add(1, 0, 1,  1,  1, 0, 0, 0, 0, "relock_in_reset");
    add(1, 0, 0,  3,  1, 0, 0, 0, 0, "restarted_pulse_high");
    add(1, 0, 0,  1,  0, 0, 0, 0, 0, "restarted_pulse_end");
    // Lock arriving exactly on the timeout cycle wins.
    add(1, 0, 0, 29,  0, 0, 0, 0, 0, "late_wait");
    add(1, 1, 0,  3,  0, 0, 0, 0, 0, "lock_wins_timeout");
    add(1, 1, 0,  3,  0, 0, 0, 0, 0, "stabilize_cnt3");
    // reset_n together with relock_req mid-STABILIZE.
    add(0, 1, 1,  1,  1, 0, 0, 0, 0, "reset_with_relock");
    add(1, 1, 0,  3,  1, 0, 0, 0, 0, "post_reset_pulse");
    add(1, 1, 0,  1,  0, 0, 0, 0, 0, "post_reset_wait");
    add(1, 1, 0,  8,  0, 0, 0, 0, 0, "post_reset_stabilize");
    add(1, 1, 0,  1,  0, 1, 1, 0, 0, "post_reset_run");

    inv_en = 1'b1;
    run_range(0, split);

    // FAULT must hold for 100 further cycles with no input activity.
    for (int c = 0; c < 100; c++) begin
      step(1);
      check_out($sformatf("fault_hold_%0d", c), {1'b1, 1'b0, 1'b0, 1'b1, 4'd2});
    end

    run_range(split, vq.size());

    inv_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
